// File: rtl/ibus_dbus_arbiter_pkg.sv
// rtl/ibus_dbus_arbiter_pkg.sv - shared types and defaults for the IBus/DBus arbiter
package ibus_dbus_arbiter_pkg;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;

  localparam int IDX_I = 0;
  localparam int IDX_D = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCK_I = 2'd1,
    ST_LOCK_D = 2'd2
  } state_e;

  // One-hot grant, bit positions match IDX_I / IDX_D
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_I    = 2'b01,
    GNT_D    = 2'b10
  } gnt_e;

endpackage

// File: rtl/ibus_dbus_arbiter_rr_arb2.sv
// rtl/ibus_dbus_arbiter_rr_arb2.sv - two-requester combinational arbiter, round-robin or fixed D priority
module rr_arb2
  import ibus_dbus_arbiter_pkg::*;
(
  input  logic req_i_i,
  input  logic req_d_i,
  input  gnt_e last_grant_i,
  input  logic fixed_d_prio_i,
  output gnt_e gnt_o
);

  always_comb begin
    gnt_o = GNT_NONE;
    if (req_i_i && req_d_i) begin
      // Tie goes to whoever was not served last, unless D is pinned as winner
      gnt_o = (fixed_d_prio_i || (last_grant_i != GNT_D)) ? GNT_D : GNT_I;
    end else if (req_i_i) begin
      gnt_o = GNT_I;
    end else if (req_d_i) begin
      gnt_o = GNT_D;
    end
  end

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// rtl/ibus_dbus_arbiter.sv - shares one memory slave port between an instruction and a data master
module ibus_dbus_arbiter
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter bit FIXED_D_PRIO = 1'b0
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic [ADDR_W-1:0]   i_IBus_Address,
  input  logic                i_IBus_Read,
  output logic [DATA_W-1:0]   o_IBus_ReadData,
  output logic                o_IBus_WaitReq,
  input  logic [ADDR_W-1:0]   i_DBus_Address,
  input  logic                i_DBus_Read,
  input  logic                i_DBus_Write,
  input  logic [DATA_W-1:0]   i_DBus_WriteData,
  input  logic [DATA_W/8-1:0] i_DBus_ByteEn,
  output logic [DATA_W-1:0]   o_DBus_ReadData,
  output logic                o_DBus_WaitReq,
  output logic [ADDR_W-1:0]   o_Mem_Address,
  output logic                o_Mem_Read,
  output logic                o_Mem_Write,
  output logic [DATA_W-1:0]   o_Mem_WriteData,
  output logic [DATA_W/8-1:0] o_Mem_ByteEn,
  input  logic [DATA_W-1:0]   i_Mem_ReadData,
  input  logic                i_Mem_WaitReq
);

  localparam int BE_W = DATA_W / 8;

  state_e     state_q, state_d;
  gnt_e       r_LastGrant, last_grant_d;
  logic [1:0] r_RdOwner, rd_owner_d;
  gnt_e       arb_gnt, gnt;
  logic       ibus_req, dbus_req, accept;

  assign ibus_req = i_IBus_Read;
  assign dbus_req = i_DBus_Read | i_DBus_Write;

  rr_arb2 u_rr_arb2 (
    .req_i_i        (ibus_req),
    .req_d_i        (dbus_req),
    .last_grant_i   (r_LastGrant),
    .fixed_d_prio_i (FIXED_D_PRIO),
    .gnt_o          (arb_gnt)
  );

  // Fresh arbitration only from IDLE; a stalled grant is pinned until accepted
  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    case (state_q)
      ST_IDLE: begin
        gnt = arb_gnt;
        if (i_Mem_WaitReq) begin
          if (arb_gnt == GNT_I)      state_d = ST_LOCK_I;
          else if (arb_gnt == GNT_D) state_d = ST_LOCK_D;
        end
      end
      ST_LOCK_I: begin
        gnt = GNT_I;
        if (!i_Mem_WaitReq) state_d = ST_IDLE;
      end
      ST_LOCK_D: begin
        gnt = GNT_D;
        if (!i_Mem_WaitReq) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_Reset) gnt = GNT_NONE;
  end

  always_comb begin
    o_Mem_Address   = '0;
    o_Mem_Read      = 1'b0;
    o_Mem_Write     = 1'b0;
    o_Mem_WriteData = '0;
    o_Mem_ByteEn    = '0;
    case (gnt)
      GNT_I: begin
        o_Mem_Address = i_IBus_Address;
        o_Mem_Read    = i_IBus_Read;
        o_Mem_ByteEn  = {BE_W{i_IBus_Read}};
      end
      GNT_D: begin
        o_Mem_Address   = i_DBus_Address;
        o_Mem_Read      = i_DBus_Read;
        o_Mem_Write     = i_DBus_Write;
        o_Mem_WriteData = i_DBus_WriteData;
        o_Mem_ByteEn    = i_DBus_ByteEn;
      end
      default: ;
    endcase
  end

  assign accept       = !i_Mem_WaitReq && (o_Mem_Read || o_Mem_Write);
  assign last_grant_d = accept ? gnt : r_LastGrant;
  assign rd_owner_d   = (accept && o_Mem_Read) ? gnt : 2'b00;

  assign o_IBus_WaitReq = !i_Reset && ((gnt == GNT_I) ? i_Mem_WaitReq : ibus_req);
  assign o_DBus_WaitReq = !i_Reset && ((gnt == GNT_D) ? i_Mem_WaitReq : dbus_req);

  assign o_IBus_ReadData = (r_RdOwner[IDX_I] && !i_Reset) ? i_Mem_ReadData : '0;
  assign o_DBus_ReadData = (r_RdOwner[IDX_D] && !i_Reset) ? i_Mem_ReadData : '0;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= ST_IDLE;
      r_LastGrant <= GNT_D;
      r_RdOwner   <= 2'b00;
    end else begin
      state_q     <= state_d;
      r_LastGrant <= last_grant_d;
      r_RdOwner   <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// tb/tb_ibus_dbus_arbiter.sv - directed self-checking bench for ibus_dbus_arbiter
module tb_ibus_dbus_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_addr, d_addr;
  logic          i_rd, d_rd, d_wr;
  logic [DW-1:0] d_wdata, m_rdata;
  logic [3:0]    d_be;
  logic          m_wait;

  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic          i_wait, d_wait, m_rd, m_wr;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_be;

  logic [DW-1:0] f_i_rdata, f_d_rdata, f_m_wdata;
  logic          f_i_wait, f_d_wait, f_m_rd, f_m_wr;
  logic [AW-1:0] f_m_addr;
  logic [3:0]    f_m_be;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  ibus_dbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_D_PRIO(1'b0)) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_IBus_Address(i_addr), .i_IBus_Read(i_rd), .o_IBus_ReadData(i_rdata), .o_IBus_WaitReq(i_wait),
    .i_DBus_Address(d_addr), .i_DBus_Read(d_rd), .i_DBus_Write(d_wr), .i_DBus_WriteData(d_wdata),
    .i_DBus_ByteEn(d_be), .o_DBus_ReadData(d_rdata), .o_DBus_WaitReq(d_wait),
    .o_Mem_Address(m_addr), .o_Mem_Read(m_rd), .o_Mem_Write(m_wr), .o_Mem_WriteData(m_wdata),
    .o_Mem_ByteEn(m_be), .i_Mem_ReadData(m_rdata), .i_Mem_WaitReq(m_wait)
  );

  ibus_dbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_D_PRIO(1'b1)) dut_fix (
    .i_Clk(clk), .i_Reset(rst),
    .i_IBus_Address(i_addr), .i_IBus_Read(i_rd), .o_IBus_ReadData(f_i_rdata), .o_IBus_WaitReq(f_i_wait),
    .i_DBus_Address(d_addr), .i_DBus_Read(d_rd), .i_DBus_Write(d_wr), .i_DBus_WriteData(d_wdata),
    .i_DBus_ByteEn(d_be), .o_DBus_ReadData(f_d_rdata), .o_DBus_WaitReq(f_d_wait),
    .o_Mem_Address(f_m_addr), .o_Mem_Read(f_m_rd), .o_Mem_Write(f_m_wr), .o_Mem_WriteData(f_m_wdata),
    .o_Mem_ByteEn(f_m_be), .i_Mem_ReadData(m_rdata), .i_Mem_WaitReq(m_wait)
  );

  task automatic set_idle();
    i_addr = '0; d_addr = '0; i_rd = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    d_wdata = '0; d_be = '0; m_rdata = '0; m_wait = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Leaves the bench at the start of the first post-reset cycle
  task automatic do_reset();
    next_cycle();
    set_idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    next_cycle();
    set_idle();
    rst = 1'b1; i_rd = 1'b1; d_wr = 1'b1; d_be = 4'hF; m_wait = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #3;
    vectors++; if ({m_rd, m_wr} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b exp 00", {m_rd, m_wr}); end
    vectors++; if (m_be !== 4'h0) begin errors++; $display("FAIL rst_byteen: got %h exp 0", m_be); end
    vectors++; if ({i_wait, d_wait} !== 2'b00) begin errors++; $display("FAIL rst_waitreq: got %b exp 00", {i_wait, d_wait}); end
    next_cycle();
    #3;
    vectors++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h exp 0", {i_rdata, d_rdata}); end
    vectors++; if (dut.r_RdOwner !== 2'b00) begin errors++; $display("FAIL rst_rdowner: got %b exp 00", dut.r_RdOwner); end
    rst = 1'b0;
  endtask

  task automatic test_i_read();
    do_reset();
    i_rd = 1'b1; i_addr = 30'h10; m_wait = 1'b0;
    #3;
    vectors++; if (m_rd !== 1'b1) begin errors++; $display("FAIL iread_mem_read: got %b exp 1", m_rd); end
    vectors++; if (m_addr !== 30'h10) begin errors++; $display("FAIL iread_addr: got %h exp 10", m_addr); end
    vectors++; if (m_be !== 4'hF) begin errors++; $display("FAIL iread_byteen: got %h exp f", m_be); end
    vectors++; if ({i_wait, d_wait, m_wr} !== 3'b000) begin errors++; $display("FAIL iread_wait_wr: got %b exp 000", {i_wait, d_wait, m_wr}); end
    next_cycle();
    i_rd = 1'b0; m_rdata = 32'hDEAD_BEEF;
    #3;
    vectors++; if (i_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL iread_idata: got %h exp deadbeef", i_rdata); end
    vectors++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL iread_ddata: got %h exp 0", d_rdata); end
    vectors++; if ({m_rd, m_be} !== 5'b0) begin errors++; $display("FAIL iread_nogrant: got %b exp 0", {m_rd, m_be}); end
    next_cycle();
    #3;
    vectors++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL iread_idata_clr: got %h exp 0", i_rdata); end
  endtask

  task automatic test_round_robin();
    logic          exp_i, prev_i;
    logic [DW-1:0] rd_val;
    do_reset();
    i_rd = 1'b1; d_rd = 1'b1; i_addr = 30'h100; d_addr = 30'h200; m_wait = 1'b0;
    for (int k = 0; k < 5; k++) begin
      exp_i  = (k % 2) == 0;
      prev_i = ((k - 1) % 2) == 0;
      rd_val = 32'hA000 + k;
      m_rdata = rd_val;
      #3;
      vectors++; if (m_addr !== (exp_i ? 30'h100 : 30'h200)) begin errors++; $display("FAIL rr_addr[%0d]: got %h exp %h", k, m_addr, exp_i ? 30'h100 : 30'h200); end
      vectors++; if ({i_wait, d_wait} !== {!exp_i, exp_i}) begin errors++; $display("FAIL rr_wait[%0d]: got %b exp %b", k, {i_wait, d_wait}, {!exp_i, exp_i}); end
      if (k > 0) begin
        vectors++; if ({i_rdata, d_rdata} !== (prev_i ? {rd_val, 32'h0} : {32'h0, rd_val}))
          begin errors++; $display("FAIL rr_rdata[%0d]: got %h/%h exp prev_i=%b val %h", k, i_rdata, d_rdata, prev_i, rd_val); end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock_d_write();
    do_reset();
    i_rd = 1'b1; i_addr = 30'h40; m_wait = 1'b0;
    next_cycle();
    i_addr = 30'h44; d_wr = 1'b1; d_addr = 30'h80; d_wdata = 32'h1234_5678; d_be = 4'hF;
    for (int c = 0; c < 4; c++) begin
      m_wait = (c < 3);
      #3;
      vectors++; if (i_wait !== 1'b1) begin errors++; $display("FAIL lockd_iwait[%0d]: got %b exp 1", c, i_wait); end
      vectors++; if (d_wait !== (c < 3)) begin errors++; $display("FAIL lockd_dwait[%0d]: got %b exp %b", c, d_wait, c < 3); end
      vectors++; if ({m_wr, m_rd, m_addr, m_wdata, m_be} !== {1'b1, 1'b0, 30'h80, 32'h1234_5678, 4'hF})
        begin errors++; $display("FAIL lockd_mem[%0d]: got wr%b rd%b a%h d%h be%h", c, m_wr, m_rd, m_addr, m_wdata, m_be); end
      if (c > 0) begin
        vectors++; if (dut.r_RdOwner !== 2'b00) begin errors++; $display("FAIL lockd_owner[%0d]: got %b exp 00", c, dut.r_RdOwner); end
      end
      next_cycle();
    end
    d_wr = 1'b0; m_wait = 1'b0;
    #3;
    vectors++; if ({i_wait, m_rd, m_addr} !== {1'b0, 1'b1, 30'h44}) begin errors++; $display("FAIL lockd_igrant: got w%b rd%b a%h exp w0 rd1 a44", i_wait, m_rd, m_addr); end
    vectors++; if (dut.r_RdOwner !== 2'b00) begin errors++; $display("FAIL lockd_wr_owner: got %b exp 00", dut.r_RdOwner); end
    next_cycle();
    i_rd = 1'b0; m_rdata = 32'h55;
    #3;
    vectors++; if ({i_rdata, d_rdata} !== {32'h55, 32'h0}) begin errors++; $display("FAIL lockd_irdata: got %h/%h exp 55/0", i_rdata, d_rdata); end
  endtask

  task automatic test_fixed_prio();
    do_reset();
    i_rd = 1'b1; d_rd = 1'b1; i_addr = 30'h300; d_addr = 30'h301; m_wait = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      vectors++; if ({f_m_addr, f_i_wait, f_d_wait} !== {30'h301, 1'b1, 1'b0})
        begin errors++; $display("FAIL fixed[%0d]: got a%h iw%b dw%b exp a301 iw1 dw0", k, f_m_addr, f_i_wait, f_d_wait); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    i_rd = 1'b1; i_addr = 30'h30; m_wait = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1; m_wait = 1'b0; m_rdata = 32'hCAFE;
    #3;
    vectors++; if ({m_rd, m_wr, m_be, i_wait, d_wait} !== 8'h0) begin errors++; $display("FAIL rstlock_in: got %b exp 0", {m_rd, m_wr, m_be, i_wait, d_wait}); end
    next_cycle();
    rst = 1'b0; set_idle(); m_rdata = 32'hCAFE;
    #3;
    vectors++; if ({m_rd, m_wr, m_be} !== 6'h0) begin errors++; $display("FAIL rstlock_strobes: got %b exp 0", {m_rd, m_wr, m_be}); end
    vectors++; if (dut.r_RdOwner !== 2'b00) begin errors++; $display("FAIL rstlock_owner: got %b exp 00", dut.r_RdOwner); end
    vectors++; if ({i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL rstlock_leak: got %h exp 0", {i_rdata, d_rdata}); end
    next_cycle();
    d_rd = 1'b1; d_addr = 30'h77;
    #3;
    vectors++; if ({m_rd, m_addr, d_wait} !== {1'b1, 30'h77, 1'b0}) begin errors++; $display("FAIL rstlock_idle: got rd%b a%h w%b exp rd1 a77 w0", m_rd, m_addr, d_wait); end
  endtask

  task automatic test_d_then_i();
    do_reset();
    d_rd = 1'b1; d_addr = 30'h60; m_wait = 1'b0;
    #3;
    vectors++; if ({m_rd, m_addr} !== {1'b1, 30'h60}) begin errors++; $display("FAIL dthen_dgrant: got rd%b a%h exp rd1 a60", m_rd, m_addr); end
    next_cycle();
    d_rd = 1'b0; i_rd = 1'b1; i_addr = 30'h61; m_rdata = 32'h1111_1111;
    #3;
    vectors++; if ({i_rdata, d_rdata} !== {32'h0, 32'h1111_1111}) begin errors++; $display("FAIL dthen_c1_rdata: got %h/%h exp 0/11111111", i_rdata, d_rdata); end
    vectors++; if ({m_rd, m_addr} !== {1'b1, 30'h61}) begin errors++; $display("FAIL dthen_igrant: got rd%b a%h exp rd1 a61", m_rd, m_addr); end
    next_cycle();
    i_rd = 1'b0; m_rdata = 32'h2222_2222;
    #3;
    vectors++; if ({i_rdata, d_rdata} !== {32'h2222_2222, 32'h0}) begin errors++; $display("FAIL dthen_c2_rdata: got %h/%h exp 22222222/0", i_rdata, d_rdata); end
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_i_read();
    test_round_robin();
    test_lock_d_write();
    test_fixed_prio();
    test_reset_mid_lock();
    test_d_then_i();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ibus_dbus_arbiter.md
IBUS_DBUS_ARBITER -- requirements
Module: ibus_dbus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 30, word-address width of all three ports.
REQ-002 Parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 Parameter FIXED_D_PRIO, default 0, meaning 1 = DBus always wins ties and 0 = round-robin.
REQ-004 Port i_Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port i_Reset, input, 1, synchronous active-high reset, sampled on the i_Clk rising edge.
REQ-006 Ports i_IBus_Address (input, ADDR_W), i_IBus_Read (input, 1), o_IBus_ReadData (output, DATA_W), o_IBus_WaitReq (output, 1) SHALL form the instruction master port.
REQ-007 Ports i_DBus_Address (input, ADDR_W), i_DBus_Read (input, 1), i_DBus_Write (input, 1), i_DBus_WriteData (input, DATA_W), i_DBus_ByteEn (input, DATA_W/8), o_DBus_ReadData (output, DATA_W), o_DBus_WaitReq (output, 1) SHALL form the data master port.
REQ-008 Ports o_Mem_Address, o_Mem_Read, o_Mem_Write, o_Mem_WriteData, o_Mem_ByteEn (outputs) and i_Mem_ReadData, i_Mem_WaitReq (inputs) SHALL form the shared slave port, with widths as in REQ-007.

Function
REQ-009 Bus protocol: a transfer is accepted in the cycle where Read or Write is high and WaitReq is low; read data is valid exactly 1 cycle after acceptance; a master holds its request stable while it sees WaitReq high.
REQ-010 FSM states: IDLE, LOCK_I, LOCK_D.
REQ-011 In IDLE, grant SHALL be decided combinationally in the same cycle, with no added latency: I only requesting gives I; D only requesting gives D; both requesting gives the master not granted last (round-robin), or D when FIXED_D_PRIO=1.
REQ-012 A DBus request is i_DBus_Read or i_DBus_Write; an IBus request is i_IBus_Read.
REQ-013 The granted master's signals SHALL drive o_Mem_*; with no grant, o_Mem_Read, o_Mem_Write and o_Mem_ByteEn SHALL be 0 and the address/data SHALL be don't-care (driven 0).
REQ-014 Granted master WaitReq SHALL equal i_Mem_WaitReq; non-granted requesting master WaitReq SHALL be 1; a non-requesting master WaitReq SHALL be 0.
REQ-015 If the grant is issued and i_Mem_WaitReq=1, go to LOCK_I or LOCK_D; the grant is held regardless of the other master until acceptance, then return to IDLE.
REQ-016 In LOCK_x, acceptance (i_Mem_WaitReq=0) SHALL return to IDLE on the next edge; the next arbitration occurs in that IDLE cycle (one lock-exit cycle, no back-to-back grant from LOCK).
REQ-017 r_LastGrant SHALL update on every acceptance to the accepted master.
REQ-018 r_RdOwner (2 bits, one-hot I/D) SHALL be registered on read acceptance and cleared otherwise.
REQ-019 o_IBus_ReadData = i_Mem_ReadData when r_RdOwner[I], else 0; same rule for o_DBus_ReadData with r_RdOwner[D].
REQ-020 Writes SHALL produce no r_RdOwner bit.
REQ-021 Simultaneous acceptance of one master and a new request from the other: the other master waits at least one cycle; requests are never dropped or merged.
REQ-022 A master dropping its request while locked is a protocol violation; behaviour is then undefined, but the FSM SHALL return to IDLE on the next acceptance or reset.

Reset
REQ-023 i_Reset SHALL force state IDLE, r_RdOwner=0, and r_LastGrant=D (first tie goes to IBus).
REQ-024 During reset, all o_Mem_* strobes, both ReadData outputs and both WaitReq outputs SHALL be 0.
REQ-025 Reset mid-lock SHALL abandon the transfer; the first post-reset cycle is IDLE.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the grant encodings (GNT_NONE, GNT_I, GNT_D) and the default widths.
REQ-027 The arbitration decision (REQ-011) SHALL be a sub-module rr_arb2: two request inputs, last-grant and fixed-priority inputs, one-hot grant output, purely combinational.

Verification
REQ-028 I-only read of addr 0x10, slave WaitReq=0: o_Mem_Read=1 the same cycle; o_IBus_ReadData=slave data (e.g. 0xDEADBEEF) the next cycle; o_DBus_ReadData=0.
REQ-029 Both masters read in the first cycle after reset, WaitReq=0: I is served in cycle 0 and D in cycle 1; with persistent requests, I and D alternate.
REQ-030 D write 0x12345678 with ByteEn 0xF, slave WaitReq high for 3 cycles while I requests: o_IBus_WaitReq=1 for 4 cycles; the IBus grant comes after the LOCK_D exit; r_RdOwner stays 0 for the write.
REQ-031 FIXED_D_PRIO=1 with both requesting continuously: D is granted every arbitration and IBus WaitReq stays 1.
REQ-032 i_Reset asserted during LOCK_I: the next cycle is IDLE, all strobes are 0, r_RdOwner=0, and no ReadData leaks to either master.
REQ-033 Read by D accepted, then I accepted the following arbitration: each master receives only its own data, and no data is delivered to the other master in either cycle.
